// File: rtl/starflux_pkg.sv
// Shared types and playfield constants for the starflux enemy, shooter and scorer blocks.
package starflux_pkg;

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    FLASH = 2'd1,
    OVER  = 2'd2
  } scorer_state_t;

  localparam logic [7:0] ENEMY_Y_DEFAULT    = 8'd100;
  localparam logic [7:0] ENEMY_W_DEFAULT    = 8'd8;
  localparam logic [7:0] BULLET_TOP_DEFAULT = 8'd119;

  // Two-digit BCD increment without saturation; callers guard the 99 case.
  function automatic logic [7:0] bcd_inc(input logic [7:0] value);
    logic [7:0] result;
    if (value[3:0] == 4'd9) begin
      result = {value[7:4] + 4'd1, 4'd0};
    end else begin
      result = {value[7:4], value[3:0] + 4'd1};
    end
    return result;
  endfunction

endpackage

// File: rtl/bcd_counter2.sv
// Two-digit BCD up-counter with carry between digits, saturating at 99.
module bcd_counter2
  import starflux_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       inc,
  output logic [7:0] value
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clock) begin
    if (reset) begin
      value <= 8'h00;
    end else if (inc && (value != 8'h99)) begin
      value <= bcd_inc(value);
    end
  end

endmodule

// File: rtl/collision_scorer.sv
// Bullet/enemy collision detect, score keeping, miss counting and game-over control.
module collision_scorer
  import starflux_pkg::*;
#(
  parameter logic [7:0] ENEMY_Y     = ENEMY_Y_DEFAULT,
  parameter logic [7:0] ENEMY_W     = ENEMY_W_DEFAULT,
  parameter logic [7:0] BULLET_TOP  = BULLET_TOP_DEFAULT,
  parameter logic [1:0] MAX_MISSES  = 2'd3,
  parameter logic [3:0] FLASH_TICKS = 4'd4
) (
  input  logic       movement_handler_clock,
  input  logic       reset,
  input  logic [7:0] enemy_x,
  input  logic [7:0] bullet_x,
  input  logic [7:0] bullet_y,
  input  logic       bullet_valid,
  output logic       hit,
  output logic       miss,
  output logic       bullet_clear,
  output logic [7:0] score_bcd,
  output logic [1:0] misses,
  output logic       enemy_flash,
  output logic       game_over
);

  scorer_state_t state;
  logic [3:0]    flash_cnt;
  logic [8:0]    x_hi;
  logic          is_hit;
  logic          is_miss;
  logic [1:0]    misses_next;

  // Right edge computed at 9 bits so an enemy near x=255 does not wrap.
  assign x_hi        = {1'b0, enemy_x} + {1'b0, ENEMY_W} - 9'd1;
  assign is_hit      = bullet_valid && (bullet_y == ENEMY_Y) &&
                       (bullet_x >= enemy_x) && ({1'b0, bullet_x} <= x_hi);
  assign is_miss     = bullet_valid && (bullet_y >= BULLET_TOP) && !is_hit;
  assign misses_next = misses + 2'd1;

  bcd_counter2 u_score (
    .clock (movement_handler_clock),
    .reset (reset),
    .inc   ((state == PLAY) && is_hit),
    .value (score_bcd)
  );

  always_ff @(posedge movement_handler_clock) begin
    if (reset) begin
      state        <= PLAY;
      flash_cnt    <= 4'd0;
      hit          <= 1'b0;
      miss         <= 1'b0;
      bullet_clear <= 1'b0;
      misses       <= 2'd0;
      enemy_flash  <= 1'b0;
      game_over    <= 1'b0;
    end else begin
      // Pulses default low every tick; only a PLAY-state event raises them.
      hit          <= 1'b0;
      miss         <= 1'b0;
      bullet_clear <= 1'b0;
      case (state)
        PLAY: begin
          if (is_hit) begin
            hit          <= 1'b1;
            bullet_clear <= 1'b1;
            flash_cnt    <= FLASH_TICKS - 4'd1;
            enemy_flash  <= 1'b1;
            state        <= FLASH;
          end else if (is_miss) begin
            miss         <= 1'b1;
            bullet_clear <= 1'b1;
            misses       <= misses_next;
            if (misses_next == MAX_MISSES) begin
              game_over <= 1'b1;
              state     <= OVER;
            end
          end
        end
        FLASH: begin
          if (flash_cnt == 4'd0) begin
            enemy_flash <= 1'b0;
            state       <= PLAY;
          end else begin
            flash_cnt <= flash_cnt - 4'd1;
          end
        end
        OVER: begin
          game_over <= 1'b1;
        end
        default: begin
          state <= PLAY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_collision_scorer.sv
// Directed, table-driven bench for collision_scorer plus multi-cycle corner sequences.
module tb_collision_scorer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] enemy_x, bullet_x, bullet_y;
  logic       bullet_valid;

  logic       hit, miss, bullet_clear, enemy_flash, game_over;
  logic [7:0] score_bcd;
  logic [1:0] misses;

  logic       b_hit, b_miss, b_clear, b_flash, b_over;
  logic [7:0] b_score;
  logic [1:0] b_misses;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  collision_scorer dut (
    .movement_handler_clock (clk),
    .reset                  (reset),
    .enemy_x                (enemy_x),
    .bullet_x               (bullet_x),
    .bullet_y               (bullet_y),
    .bullet_valid           (bullet_valid),
    .hit                    (hit),
    .miss                   (miss),
    .bullet_clear           (bullet_clear),
    .score_bcd              (score_bcd),
    .misses                 (misses),
    .enemy_flash            (enemy_flash),
    .game_over              (game_over)
  );

  collision_scorer #(.BULLET_TOP(8'd100)) dut_top100 (
    .movement_handler_clock (clk),
    .reset                  (reset),
    .enemy_x                (enemy_x),
    .bullet_x               (bullet_x),
    .bullet_y               (bullet_y),
    .bullet_valid           (bullet_valid),
    .hit                    (b_hit),
    .miss                   (b_miss),
    .bullet_clear           (b_clear),
    .score_bcd              (b_score),
    .misses                 (b_misses),
    .enemy_flash            (b_flash),
    .game_over              (b_over)
  );

  typedef struct {
    logic [7:0] ex, bx, by;
    logic       v;
    logic       hit, miss;
    logic [7:0] score;
    logic [1:0] misses;
    logic       flash, over;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Apply inputs for one tick and sample 1 time unit after the edge.
  task automatic step(input logic [7:0] ex, input logic [7:0] bx, input logic [7:0] by, input logic v);
    enemy_x = ex; bullet_x = bx; bullet_y = by; bullet_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(8'd0, 8'd0, 8'd0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    reset = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".hit"},    {31'd0, hit},          32'd0);
    check({tag, ".miss"},   {31'd0, miss},         32'd0);
    check({tag, ".clear"},  {31'd0, bullet_clear}, 32'd0);
    check({tag, ".score"},  {24'd0, score_bcd},    32'h00);
    check({tag, ".misses"}, {30'd0, misses},       32'd0);
    check({tag, ".flash"},  {31'd0, enemy_flash},  32'd0);
    check({tag, ".over"},   {31'd0, game_over},    32'd0);
  endtask

  // Hit the enemy at x=50, then ride out the 4-tick flash.
  task automatic hit_and_wait();
    step(8'd50, 8'd57, 8'd100, 1'b1);
    repeat (4) idle();
  endtask

  initial begin
    reset = 1'b0;
    enemy_x = '0; bullet_x = '0; bullet_y = '0; bullet_valid = 1'b0;

    //          ex      bx      by      v    hit  miss score  mis  fl   ov
    tbl.push_back('{8'd0,   8'd0,   8'd0,   0,   0,   0, 8'h00, 2'd0, 0, 0}); // idle
    tbl.push_back('{8'd50,  8'd57,  8'd100, 1,   1,   0, 8'h01, 2'd0, 1, 0}); // right-edge hit
    tbl.push_back('{8'd50,  8'd57,  8'd100, 1,   0,   0, 8'h01, 2'd0, 1, 0}); // ignored in FLASH
    tbl.push_back('{8'd0,   8'd0,   8'd0,   0,   0,   0, 8'h01, 2'd0, 1, 0});
    tbl.push_back('{8'd0,   8'd0,   8'd0,   0,   0,   0, 8'h01, 2'd0, 1, 0});
    tbl.push_back('{8'd0,   8'd0,   8'd0,   0,   0,   0, 8'h01, 2'd0, 0, 0}); // back in PLAY
    tbl.push_back('{8'd50,  8'd58,  8'd100, 1,   0,   0, 8'h01, 2'd0, 0, 0}); // one past right edge
    tbl.push_back('{8'd50,  8'd50,  8'd100, 1,   1,   0, 8'h02, 2'd0, 1, 0}); // left-edge hit
    tbl.push_back('{8'd0,   8'd0,   8'd0,   0,   0,   0, 8'h02, 2'd0, 1, 0});
    tbl.push_back('{8'd0,   8'd0,   8'd0,   0,   0,   0, 8'h02, 2'd0, 1, 0});
    tbl.push_back('{8'd0,   8'd0,   8'd0,   0,   0,   0, 8'h02, 2'd0, 1, 0});
    tbl.push_back('{8'd0,   8'd0,   8'd0,   0,   0,   0, 8'h02, 2'd0, 0, 0});
    tbl.push_back('{8'd252, 8'd255, 8'd100, 1,   1,   0, 8'h03, 2'd0, 1, 0}); // no wrap at 255
    tbl.push_back('{8'd0,   8'd0,   8'd0,   0,   0,   0, 8'h03, 2'd0, 1, 0});
    tbl.push_back('{8'd0,   8'd0,   8'd0,   0,   0,   0, 8'h03, 2'd0, 1, 0});
    tbl.push_back('{8'd0,   8'd0,   8'd0,   0,   0,   0, 8'h03, 2'd0, 1, 0});
    tbl.push_back('{8'd0,   8'd0,   8'd0,   0,   0,   0, 8'h03, 2'd0, 0, 0});
    tbl.push_back('{8'd252, 8'd251, 8'd100, 1,   0,   0, 8'h03, 2'd0, 0, 0}); // left of enemy
    tbl.push_back('{8'd50,  8'd57,  8'd100, 0,   0,   0, 8'h03, 2'd0, 0, 0}); // not valid
    tbl.push_back('{8'd0,   8'd0,   8'd118, 1,   0,   0, 8'h03, 2'd0, 0, 0}); // just below top
    tbl.push_back('{8'd0,   8'd0,   8'd119, 1,   0,   1, 8'h03, 2'd1, 0, 0}); // miss 1
    tbl.push_back('{8'd0,   8'd0,   8'd119, 1,   0,   1, 8'h03, 2'd2, 0, 0}); // lingering bullet counts
    tbl.push_back('{8'd0,   8'd0,   8'd200, 1,   0,   1, 8'h03, 2'd3, 0, 1}); // miss 3, game over
    tbl.push_back('{8'd50,  8'd57,  8'd100, 1,   0,   0, 8'h03, 2'd3, 0, 1}); // frozen in OVER
    tbl.push_back('{8'd0,   8'd0,   8'd119, 1,   0,   0, 8'h03, 2'd3, 0, 1});

    do_reset();
    check_reset_values("reset");

    for (int i = 0; i < tbl.size(); i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      step(tbl[i].ex, tbl[i].bx, tbl[i].by, tbl[i].v);
      check({tag, ".hit"},    {31'd0, hit},          {31'd0, tbl[i].hit});
      check({tag, ".miss"},   {31'd0, miss},         {31'd0, tbl[i].miss});
      check({tag, ".clear"},  {31'd0, bullet_clear}, {31'd0, tbl[i].hit | tbl[i].miss});
      check({tag, ".score"},  {24'd0, score_bcd},    {24'd0, tbl[i].score});
      check({tag, ".misses"}, {30'd0, misses},       {30'd0, tbl[i].misses});
      check({tag, ".flash"},  {31'd0, enemy_flash},  {31'd0, tbl[i].flash});
      check({tag, ".over"},   {31'd0, game_over},    {31'd0, tbl[i].over});
    end

    // Reset while in OVER, then score from zero.
    do_reset();
    check_reset_values("rst_over");
    step(8'd50, 8'd57, 8'd100, 1'b1);
    check("rst_over.rehit",   {31'd0, hit},       32'd1);
    check("rst_over.rescore", {24'd0, score_bcd}, 32'h01);

    // Reset in the middle of FLASH; a flashing state must not survive it.
    idle();
    check("rst_flash.pre", {31'd0, enemy_flash}, 32'd1);
    do_reset();
    check_reset_values("rst_flash");
    step(8'd50, 8'd57, 8'd100, 1'b1);
    check("rst_flash.rehit",   {31'd0, hit},         32'd1);
    check("rst_flash.rescore", {24'd0, score_bcd},   32'h01);
    check("rst_flash.flash",   {31'd0, enemy_flash}, 32'd1);

    // BCD carry and saturation.
    do_reset();
    repeat (9) hit_and_wait();
    check("bcd.09", {24'd0, score_bcd}, 32'h09);
    hit_and_wait();
    check("bcd.10", {24'd0, score_bcd}, 32'h10);
    repeat (89) hit_and_wait();
    check("bcd.99", {24'd0, score_bcd}, 32'h99);
    step(8'd50, 8'd57, 8'd100, 1'b1);
    check("bcd.sat_hit",   {31'd0, hit},          32'd1);
    check("bcd.sat_clear", {31'd0, bullet_clear}, 32'd1);
    check("bcd.sat_score", {24'd0, score_bcd},    32'h99);

    // BULLET_TOP == ENEMY_Y: a miss at the row edge, then hit wins over miss.
    do_reset();
    step(8'd50, 8'd0, 8'd100, 1'b1);
    check("top100.miss",   {31'd0, b_miss},   32'd1);
    check("top100.misses", {30'd0, b_misses}, 32'd1);
    step(8'd50, 8'd57, 8'd100, 1'b1);
    check("top100.hit",       {31'd0, b_hit},    32'd1);
    check("top100.no_miss",   {31'd0, b_miss},   32'd0);
    check("top100.misses_eq", {30'd0, b_misses}, 32'd1);
    check("top100.score",     {24'd0, b_score},  32'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
